// File: rtl/traffic_pkg.sv
// Shared types for the traffic light sequencer: phase enumeration, lamp
// encodings, default phase durations and per-phase lamp/sequence lookups.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        AR1   = 3'd2,
        SG    = 3'd3,
        SY    = 3'd4,
        AR2   = 3'd5,
        NIGHT = 3'd6
    } state_t;

    // Lamp encodings are {R,Y,G}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int DEF_MAIN_GREEN = 30;
    localparam int DEF_SIDE_GREEN = 20;
    localparam int DEF_YELLOW     = 3;
    localparam int DEF_ALL_RED    = 2;
    localparam int DEF_PED_MIN    = 5;

    function automatic state_t next_phase(input state_t s);
        case (s)
            MG:      next_phase = MY;
            MY:      next_phase = AR1;
            AR1:     next_phase = SG;
            SG:      next_phase = SY;
            SY:      next_phase = AR2;
            default: next_phase = MG;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(input state_t s);
        case (s)
            MG:      main_lamp = GRN;
            MY:      main_lamp = YEL;
            default: main_lamp = RED;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        case (s)
            SG:      side_lamp = GRN;
            SY:      side_lamp = YEL;
            default: side_lamp = RED;
        endcase
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the 1 Hz divider output into the F1 domain and turns each rising
// edge into a single-cycle tick.
module tick_sync (
    input  logic F1,
    input  logic rst_n,
    input  logic F2,
    output logic tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge F1) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= F2;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Cleared r_prev lets a level already high at reset release count as a rise
    assign tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/light_sequencer.sv
// Two-road traffic light controller: fixed phase cycle with pedestrian
// shortening of main green and a night flashing-yellow mode.
module light_sequencer
    import traffic_pkg::*;
#(
    parameter int MAIN_GREEN = DEF_MAIN_GREEN,
    parameter int SIDE_GREEN = DEF_SIDE_GREEN,
    parameter int YELLOW     = DEF_YELLOW,
    parameter int ALL_RED    = DEF_ALL_RED,
    parameter int PED_MIN    = DEF_PED_MIN
) (
    input  logic       F1,
    input  logic       rst_n,
    input  logic       F2,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [5:0] remain,
    output logic       ped_pending
);

    localparam logic [5:0] PED_MIN_L = 6'(PED_MIN);
    localparam logic [5:0] ALL_RED_L = 6'(ALL_RED);

    function automatic logic [5:0] phase_len(input state_t s);
        case (s)
            MG:       phase_len = 6'(MAIN_GREEN);
            SG:       phase_len = 6'(SIDE_GREEN);
            MY, SY:   phase_len = 6'(YELLOW);
            AR1, AR2: phase_len = ALL_RED_L;
            default:  phase_len = 6'd0;
        endcase
    endfunction

    logic       w_tick;
    state_t     w_next;
    state_t     r_state;
    logic [5:0] r_remain;
    logic       r_ped;
    logic       r_flash_on;
    logic [2:0] r_main;
    logic [2:0] r_side;

    tick_sync u_tick_sync (
        .F1    (F1),
        .rst_n (rst_n),
        .F2    (F2),
        .tick  (w_tick)
    );

    assign w_next = next_phase(r_state);

    always_ff @(posedge F1) begin
        if (!rst_n) begin
            r_state    <= AR2;
            r_remain   <= ALL_RED_L;
            r_ped      <= 1'b0;
            r_flash_on <= 1'b0;
            r_main     <= RED;
            r_side     <= RED;
        end else begin
            if (ped_req)
                r_ped <= 1'b1;
            if (w_tick) begin
                if (night && r_state != NIGHT) begin
                    r_state    <= NIGHT;
                    r_remain   <= 6'd0;
                    r_flash_on <= 1'b1;
                    r_main     <= YEL;
                    r_side     <= YEL;
                end else if (r_state == NIGHT) begin
                    if (!night) begin
                        r_state    <= AR2;
                        r_remain   <= ALL_RED_L;
                        r_flash_on <= 1'b0;
                        r_main     <= RED;
                        r_side     <= RED;
                    end else begin
                        r_flash_on <= ~r_flash_on;
                        r_main     <= r_flash_on ? OFF : YEL;
                        r_side     <= r_flash_on ? OFF : YEL;
                    end
                end else if (r_state == MG && r_ped && r_remain > PED_MIN_L) begin
                    r_remain <= PED_MIN_L;
                end else if (r_remain <= 6'd1) begin
                    r_state  <= w_next;
                    r_remain <= phase_len(w_next);
                    r_main   <= main_lamp(w_next);
                    r_side   <= side_lamp(w_next);
                    // Side green serves the crossing, so it consumes the request
                    if (w_next == SG)
                        r_ped <= 1'b0;
                end else begin
                    r_remain <= r_remain - 6'd1;
                end
            end
        end
    end

    assign main_light  = r_main;
    assign side_light  = r_side;
    assign remain      = r_remain;
    assign ped_pending = r_ped;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with default durations.
module tb_light_sequencer;

    logic       F1 = 1'b0;
    logic       rst_n;
    logic       F2;
    logic       ped_req;
    logic       night;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [5:0] remain;
    logic       ped_pending;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] L_0 = 3'b000;

    light_sequencer dut (
        .F1          (F1),
        .rst_n       (rst_n),
        .F2          (F2),
        .ped_req     (ped_req),
        .night       (night),
        .main_light  (main_light),
        .side_light  (side_light),
        .remain      (remain),
        .ped_pending (ped_pending)
    );

    always #5 F1 = ~F1;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] m, input logic [2:0] s,
                           input logic [5:0] r);
        chk({tag, ".main"},   {3'b000, main_light}, {3'b000, m});
        chk({tag, ".side"},   {3'b000, side_light}, {3'b000, s});
        chk({tag, ".remain"}, remain, r);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge F1);
        #1;
    endtask

    // One 1 Hz period: 4 cycles high then 4 low, enough for sync and update
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            F2 = 1'b1;
            cyc(4);
            F2 = 1'b0;
            cyc(4);
        end
    endtask

    task automatic ped_pulse();
        ped_req = 1'b1;
        cyc(1);
        ped_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; F2 = 1'b0; ped_req = 1'b0; night = 1'b0;
        cyc(3);
        chk_out("reset", L_R, L_R, 6'd2);
        chk("reset.ped", {5'd0, ped_pending}, 6'd0);
        rst_n = 1'b1;
        cyc(2);

        // Power-up all-red then main green
        tick(1);
        chk_out("ar2_t1", L_R, L_R, 6'd1);
        tick(1);
        chk_out("mg_entry", L_G, L_R, 6'd30);

        // Full cycle without inputs
        tick(1);
        chk_out("mg_dec", L_G, L_R, 6'd29);
        tick(29);
        chk_out("my_entry", L_Y, L_R, 6'd3);
        tick(3);
        chk_out("ar1_entry", L_R, L_R, 6'd2);
        tick(2);
        chk_out("sg_entry", L_R, L_G, 6'd20);
        tick(20);
        chk_out("sy_entry", L_R, L_Y, 6'd3);
        tick(3);
        chk_out("ar2_entry", L_R, L_R, 6'd2);
        tick(2);
        chk_out("mg_again", L_G, L_R, 6'd30);

        // Pedestrian shortening at remain=20
        tick(10);
        chk_out("mg_20", L_G, L_R, 6'd20);
        ped_pulse();
        chk("ped_set", {5'd0, ped_pending}, 6'd1);
        chk("no_tick_hold", remain, 6'd20);
        tick(1);
        chk_out("ped_short", L_G, L_R, 6'd5);
        tick(5);
        chk_out("ped_my", L_Y, L_R, 6'd3);
        chk("ped_held", {5'd0, ped_pending}, 6'd1);
        tick(5);
        chk_out("ped_sg", L_R, L_G, 6'd20);
        chk("ped_clr", {5'd0, ped_pending}, 6'd0);

        // Request at remain=4 does not lengthen or shorten
        tick(25);
        chk_out("mg_b", L_G, L_R, 6'd30);
        tick(26);
        chk("mg_4", remain, 6'd4);
        ped_pulse();
        tick(1);
        chk_out("ped_late", L_G, L_R, 6'd3);
        chk("ped_late_set", {5'd0, ped_pending}, 6'd1);

        // Night mode entered from SG remain=12
        tick(8);
        chk_out("sg_c", L_R, L_G, 6'd20);
        chk("ped_clr2", {5'd0, ped_pending}, 6'd0);
        tick(8);
        chk("sg_12", remain, 6'd12);
        night = 1'b1;
        cyc(2);
        chk_out("night_wait", L_R, L_G, 6'd12);
        tick(1);
        chk_out("night_y1", L_Y, L_Y, 6'd0);
        tick(1);
        chk_out("night_off1", L_0, L_0, 6'd0);
        tick(1);
        chk_out("night_y2", L_Y, L_Y, 6'd0);
        tick(1);
        chk_out("night_off2", L_0, L_0, 6'd0);
        night = 1'b0;
        tick(1);
        chk_out("night_exit", L_R, L_R, 6'd2);
        tick(1);
        chk("night_ar2", remain, 6'd1);
        tick(1);
        chk_out("night_mg", L_G, L_R, 6'd30);

        // Reset in the middle of side yellow
        tick(55);
        chk_out("sy_c", L_R, L_Y, 6'd3);
        tick(1);
        chk("sy_2", remain, 6'd2);
        rst_n = 1'b0;
        cyc(1);
        chk_out("mid_rst", L_R, L_R, 6'd2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_ar2", remain, 6'd1);
        tick(1);
        chk_out("rst_mg", L_G, L_R, 6'd30);

        // F2 stuck high yields exactly one tick
        F2 = 1'b1;
        cyc(1000);
        chk("f2_hold", remain, 6'd29);
        F2 = 1'b0;
        cyc(4);
        chk("f2_release", remain, 6'd29);
        tick(1);
        chk("f2_next", remain, 6'd28);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
